// File: rtl/a5_frame_sequencer.sv
`default_nettype none
// -----------------------------------------------------------------------------
// a5_frame_sequencer : loads key/frame into the A5 keystream buffer, pulls a
// fixed number of words per frame and streams them over valid/ready.
// Revision 1.0
// -----------------------------------------------------------------------------
module a5_frame_sequencer #(
  parameter int WORDS_PER_FRAME = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] cfg_key,
  input  logic [21:0] cfg_frame,
  input  logic        start,
  input  logic        stop,
  output logic        busy,
  output logic [21:0] frame_num,
  output logic        buf_load,
  output logic [63:0] buf_key,
  output logic [21:0] buf_frame,
  output logic        buf_rd_en,
  input  logic [31:0] buf_data,
  input  logic        buf_empty,
  output logic [31:0] ks_data,
  output logic        ks_valid,
  input  logic        ks_ready,
  output logic        ks_last,
  output logic [21:0] ks_frame
);

  localparam logic [7:0] C_WPF  = 8'(WORDS_PER_FRAME);
  localparam logic [7:0] C_LAST = 8'(WORDS_PER_FRAME - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] key_q, key_d;
  logic [21:0] frame_q, frame_d;
  logic [7:0]  count_q, count_d;
  logic        stop_req_q, stop_req_d;
  logic [31:0] ks_data_q, ks_data_d;
  logic        ks_valid_q, ks_valid_d;
  logic        ks_last_q, ks_last_d;
  logic [21:0] ks_frame_q, ks_frame_d;

  logic        pop;
  logic        out_free;

  // The output slot is free when empty or being accepted this cycle.
  assign out_free = !ks_valid_q || ks_ready;
  assign pop      = (state_q == S_RUN) && !buf_empty && out_free && (count_q < C_WPF);

  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    frame_d    = frame_q;
    count_d    = count_q;
    stop_req_d = stop_req_q;
    ks_data_d  = ks_data_q;
    ks_valid_d = ks_valid_q;
    ks_last_d  = ks_last_q;
    ks_frame_d = ks_frame_q;

    if (stop && (state_q != S_IDLE)) begin
      stop_req_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          key_d   = cfg_key;
          frame_d = cfg_frame;
          state_d = S_LOAD;
          if (stop) begin
            stop_req_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        count_d = 8'd0;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (pop) begin
          count_d = count_q + 8'd1;
          if (count_q == C_LAST) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (out_free) begin
          if (stop_req_q) begin
            stop_req_d = 1'b0;
            state_d    = S_IDLE;
          end else begin
            frame_d = frame_q + 22'd1;
            state_d = S_LOAD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (pop) begin
      ks_data_d  = buf_data;
      ks_frame_d = frame_q;
      ks_last_d  = (count_q == C_LAST);
      ks_valid_d = 1'b1;
    end else if (ks_valid_q && ks_ready) begin
      ks_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      key_q      <= 64'd0;
      frame_q    <= 22'd0;
      count_q    <= 8'd0;
      stop_req_q <= 1'b0;
      ks_data_q  <= 32'd0;
      ks_valid_q <= 1'b0;
      ks_last_q  <= 1'b0;
      ks_frame_q <= 22'd0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      frame_q    <= frame_d;
      count_q    <= count_d;
      stop_req_q <= stop_req_d;
      ks_data_q  <= ks_data_d;
      ks_valid_q <= ks_valid_d;
      ks_last_q  <= ks_last_d;
      ks_frame_q <= ks_frame_d;
    end
  end

  assign busy      = (state_q != S_IDLE) || ks_valid_q;
  assign frame_num = frame_q;
  assign buf_load  = (state_q == S_LOAD);
  assign buf_key   = key_q;
  assign buf_frame = frame_q;
  assign buf_rd_en = pop;
  assign ks_data   = ks_data_q;
  assign ks_valid  = ks_valid_q;
  assign ks_last   = ks_last_q;
  assign ks_frame  = ks_frame_q;

endmodule
`default_nettype wire

// File: doc/a5_frame_sequencer.md
# a5_frame_sequencer

Sequencing controller placed in front of the A5 keystream buffer. It latches a session key and starting frame number, issues the buffer's load pulse, pulls a fixed number of 32-bit keystream words per frame, and presents them to a single downstream consumer over a valid/ready handshake. After each frame it increments the frame number and reloads the buffer automatically until stopped.

## Interface
Parameters:
- WORDS_PER_FRAME, default 8: keystream words delivered per frame; legal range 1..255. The default gives 256 bits, which covers a 228-bit GSM frame.

Ports:
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- cfg_key  in  64  session key; sampled only on an accepted start
- cfg_frame  in  22  starting frame number; sampled only on an accepted start
- start  in  1  single-cycle request to begin a session; ignored unless in IDLE
- stop  in  1  single-cycle request to end the session at the next frame boundary
- busy  out  1  high when state is not IDLE, or when ks_valid is high
- frame_num  out  22  frame number currently loaded into the buffer
- buf_load  out  1  one-cycle load/flush pulse to the buffer
- buf_key  out  64  key to the buffer; held stable between loads
- buf_frame  out  22  frame to the buffer; equals frame_num
- buf_rd_en  out  1  pops one word from the buffer
- buf_data  in  32  buffer head word; valid whenever buf_empty is 0
- buf_empty  in  1  buffer holds no word
- ks_data  out  32  keystream word to the consumer
- ks_valid  out  1  ks_data, ks_last and ks_frame are valid
- ks_ready  in  1  consumer accepts the word when ks_valid and ks_ready are both high
- ks_last  out  1  marks the final word of a frame
- ks_frame  out  22  frame number the presented word belongs to

## Operation
- States: IDLE, LOAD, RUN, DRAIN.
- Reset: state goes to IDLE. Every output goes to 0: busy, frame_num, buf_load, buf_key, buf_frame, buf_rd_en, ks_data, ks_valid, ks_last, ks_frame. Word counter and stop_req also clear.
- IDLE, start=1: latch cfg_key into the key register and cfg_frame into frame_num, then go to LOAD.
- LOAD: buf_load=1 for exactly this one cycle. Clear the word counter, then go to RUN.
- RUN:
  - buf_rd_en = !buf_empty && (!ks_valid || ks_ready) && (count < WORDS_PER_FRAME). This is combinational and asserted only in RUN.
  - On a pop, the output register loads: ks_data←buf_data, ks_frame←frame_num, ks_last←(count==WORDS_PER_FRAME-1), ks_valid←1. Then count increments.
  - Once the last word is popped, go to DRAIN.
- Output register: when the consumer accepts a word and no pop happens in the same cycle, ks_valid←0. While ks_valid=1 and ks_ready=0, ks_data, ks_last and ks_frame hold.
- DRAIN: wait until ks_valid=0, or until ks_valid=1 and ks_ready=1 in this cycle. Then:
  - If stop_req is set, go to IDLE and clear stop_req.
  - Otherwise frame_num←frame_num+1, modulo 2^22 (22'h3FFFFF wraps to 0), and go to LOAD.
- stop_req: set by stop in any state other than IDLE. Also set by a start and stop arriving in the same cycle in IDLE. A stop alone in IDLE is ignored. The frame in progress always completes fully.
- start outside IDLE: ignored. The key and frame registers do not change.
- The buffer's internal warm-up and stall behaviour is opaque here. The controller only waits on buf_empty.

## Timing
- start sampled in cycle T → LOAD in T+1, with buf_load=1 in T+1 → RUN from T+2.
- Pop in cycle t → ks_valid=1 in t+1. This gives a throughput of one word per cycle when the buffer is non-empty and ks_ready=1.
- The last word is accepted in cycle t → frame_num updates and LOAD occurs in cycle t+1. The next frame's buf_load is in t+1.
- buf_key and buf_frame change only on the clock edge entering LOAD, and are stable for at least the whole LOAD cycle.
- Reset asserted mid-frame: the next cycle is IDLE with all outputs 0. No buf_load is issued and any partial output is discarded.
- No combinational path exists from ks_ready to ks_valid. buf_rd_en does depend combinationally on ks_ready and buf_empty.

## Test plan
- Reset, then start with cfg_key=64'h0123456789ABCDEF, cfg_frame=22'h134, consumer always ready, buffer model with fixed latency → buf_load pulses once with buf_key and buf_frame matching. Exactly 8 words appear with ks_frame=22'h134, ks_last only on word 8, and the next buf_load carries frame 22'h135.
- Consumer deasserts ks_ready for 5 cycles while words are pending → ks_data and ks_frame are held, buf_rd_en=0, and no word is lost or duplicated. Order matches the buffer-model contents.
- cfg_frame=22'h3FFFFF, run two frames → the second frame uses buf_frame=0 and ks_frame=0.
- stop pulsed during word 3 of a frame → all 8 words of that frame are delivered, then IDLE with busy=0 and no further buf_load. A start issued mid-frame is ignored: frame_num is unchanged.
- Reset asserted in RUN with ks_valid=1 → in the next cycle ks_valid=0, state is IDLE, and all outputs are 0. A subsequent start behaves as in the first scenario.
- WORDS_PER_FRAME=1 with start and stop in the same cycle → exactly one word with ks_last=1 and one buf_load, then IDLE.
